// File: rtl/fft_fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_fx_pkg
//  Description : Shared fixed-point definitions for the FFT datapath:
//                rounding-mode encodings and saturation bound helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_fx_pkg;

    // Rounding mode encodings carried alongside each sample
    localparam logic RND_TRUNC  = 1'b0;   // floor (plain arithmetic shift)
    localparam logic RND_HALFUP = 1'b1;   // add half an LSB before the shift

    // Largest representable signed value for a w-bit result
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest representable signed value for a w-bit result
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage : fft_fx_pkg
`default_nettype wire

// File: rtl/fx_cmult_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fx_cmult_pipe_if
//  Description : Sample/result handshake bundle of the pipelined complex
//                multiplier. The multiplier is the slave, the sample source
//                and result sink together form the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fx_cmult_pipe_if #(
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] a_re;
    logic signed [WIDTH-1:0] a_im;
    logic signed [WIDTH-1:0] b_re;
    logic signed [WIDTH-1:0] b_im;
    logic                    rnd_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] p_re;
    logic signed [WIDTH-1:0] p_im;
    logic                    out_ovf;
    logic                    ovf_sticky;
    logic                    ovf_clr;

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, rnd_mode, out_ready, ovf_clr,
        output in_ready, out_valid, p_re, p_im, out_ovf, ovf_sticky
    );

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, rnd_mode, out_ready, ovf_clr,
        input  in_ready, out_valid, p_re, p_im, out_ovf, ovf_sticky
    );
endinterface : fx_cmult_pipe_if
`default_nettype wire

// File: rtl/fx_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fx_round_sat
//  Description : Combinational requantiser: optional half-up rounding,
//                arithmetic right shift by FRAC, clamp to OUT_W bits with an
//                overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_round_sat
    import fft_fx_pkg::*;
#(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int FRAC  = 15
) (
    input  logic signed [IN_W-1:0]  din_i,
    input  logic                    rnd_i,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    ovf_o
);

    // One guard bit so the rounding bias can never wrap the sum
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(longint'(1) <<< (FRAC - 1));
    localparam logic signed [EXT_W-1:0] ZERO = '0;
    localparam logic signed [EXT_W-1:0] MAXV = EXT_W'(sat_max(OUT_W));
    localparam logic signed [EXT_W-1:0] MINV = EXT_W'(sat_min(OUT_W));

    logic signed [EXT_W-1:0] sum_d;
    logic signed [EXT_W-1:0] shift_d;

    // Bias, floor-shift, then clamp anything outside the output range
    always_comb begin
        sum_d   = EXT_W'(din_i) + ((rnd_i == RND_HALFUP) ? HALF : ZERO);
        shift_d = sum_d >>> FRAC;
        dout_o  = shift_d[OUT_W-1:0];
        ovf_o   = 1'b0;
        if (shift_d > MAXV) begin
            dout_o = MAXV[OUT_W-1:0];
            ovf_o  = 1'b1;
        end else if (shift_d < MINV) begin
            dout_o = MINV[OUT_W-1:0];
            ovf_o  = 1'b1;
        end
    end

endmodule : fx_round_sat
`default_nettype wire

// File: rtl/fx_cmult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fx_cmult_pipe
//  Description : Three-stage pipelined signed fixed-point complex multiplier
//                (operand register, partial products, requantise/saturate)
//                with valid/ready flow control and overflow reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_cmult_pipe
    import fft_fx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    fx_cmult_pipe_if.slave  bus
);

    localparam int PW = 2 * WIDTH;       // partial product width
    localparam int SW = 2 * WIDTH + 1;   // sum/difference width

    logic adv;

    // Stage 1: captured operands
    logic                    s1_v_q;
    logic signed [WIDTH-1:0] s1_a_re_q, s1_a_im_q, s1_b_re_q, s1_b_im_q;
    logic                    s1_rnd_q;

    // Stage 2: partial products
    logic                    s2_v_q;
    logic signed [PW-1:0]    s2_rr_d, s2_ii_d, s2_ri_d, s2_ir_d;
    logic signed [PW-1:0]    s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
    logic                    s2_rnd_q;

    // Stage 3: requantised result
    logic signed [SW-1:0]    s3_re_d, s3_im_d;
    logic signed [WIDTH-1:0] p_re_d, p_im_d;
    logic                    ovf_re_d, ovf_im_d;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] p_re_q, p_im_q;
    logic                    out_ovf_q;
    logic                    sticky_d, sticky_q;

    // The whole pipe moves together whenever the output slot is free or drained
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1 register: operands, rounding mode and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_a_re_q <= '0;
            s1_a_im_q <= '0;
            s1_b_re_q <= '0;
            s1_b_im_q <= '0;
            s1_rnd_q  <= RND_TRUNC;
        end else if (adv) begin
            s1_v_q    <= bus.in_valid;
            s1_a_re_q <= bus.a_re;
            s1_a_im_q <= bus.a_im;
            s1_b_re_q <= bus.b_re;
            s1_b_im_q <= bus.b_im;
            s1_rnd_q  <= bus.rnd_mode;
        end
    end

    // Full-precision signed partial products (operands sign-extended first)
    always_comb begin
        s2_rr_d = PW'(s1_a_re_q) * PW'(s1_b_re_q);
        s2_ii_d = PW'(s1_a_im_q) * PW'(s1_b_im_q);
        s2_ri_d = PW'(s1_a_re_q) * PW'(s1_b_im_q);
        s2_ir_d = PW'(s1_a_im_q) * PW'(s1_b_re_q);
    end

    // Stage 2 register: partial products travel with their rounding mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q   <= 1'b0;
            s2_rr_q  <= '0;
            s2_ii_q  <= '0;
            s2_ri_q  <= '0;
            s2_ir_q  <= '0;
            s2_rnd_q <= RND_TRUNC;
        end else if (adv) begin
            s2_v_q   <= s1_v_q;
            s2_rr_q  <= s2_rr_d;
            s2_ii_q  <= s2_ii_d;
            s2_ri_q  <= s2_ri_d;
            s2_ir_q  <= s2_ir_d;
            s2_rnd_q <= s1_rnd_q;
        end
    end

    // One extra bit keeps (-1)(-1) - (-1)(+1) style sums from wrapping
    always_comb begin
        s3_re_d = SW'(s2_rr_q) - SW'(s2_ii_q);
        s3_im_d = SW'(s2_ri_q) + SW'(s2_ir_q);
    end

    fx_round_sat #(
        .IN_W  (SW),
        .OUT_W (WIDTH),
        .FRAC  (FRAC)
    ) u_rs_re (
        .din_i  (s3_re_d),
        .rnd_i  (s2_rnd_q),
        .dout_o (p_re_d),
        .ovf_o  (ovf_re_d)
    );

    fx_round_sat #(
        .IN_W  (SW),
        .OUT_W (WIDTH),
        .FRAC  (FRAC)
    ) u_rs_im (
        .din_i  (s3_im_d),
        .rnd_i  (s2_rnd_q),
        .dout_o (p_im_d),
        .ovf_o  (ovf_im_d)
    );

    // Stage 3 / output register: held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s2_v_q;
            p_re_q      <= p_re_d;
            p_im_q      <= p_im_d;
            out_ovf_q   <= s2_v_q && (ovf_re_d || ovf_im_d);
        end
    end

    // Sticky overflow: clear first so a simultaneous transferred overflow wins
    always_comb begin
        sticky_d = sticky_q;
        if (bus.ovf_clr) begin
            sticky_d = 1'b0;
        end
        if (out_valid_q && bus.out_ready && out_ovf_q) begin
            sticky_d = 1'b1;
        end
    end

    // Sticky overflow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.p_re       = p_re_q;
    assign bus.p_im       = p_im_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.ovf_sticky = sticky_q;

endmodule : fx_cmult_pipe
`default_nettype wire

// File: doc/fx_cmult_pipe.md
Name: fx_cmult_pipe

Overview:
- Pipelined, parametrised signed fixed-point complex multiplier for the FFT butterfly/twiddle path. Supersedes the combinational real-only multiplier.
- Computes (a_re + j·a_im)·(b_re + j·b_im) in Q(WIDTH-FRAC).FRAC.
- Adds correct two's-complement arithmetic, selectable truncate/round, output saturation with overflow flags, and a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 16: bit width of every real/imag operand and result.
- FRAC, 15: number of fractional bits; legal range 1..WIDTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- a_re, a_im  in  WIDTH each  operand A, signed.
- b_re, b_im  in  WIDTH each  operand B (twiddle), signed.
- rnd_mode  in  1  0 = truncate (floor), 1 = round half up; sampled with the data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- p_re, p_im  out  WIDTH each  product, signed, saturated.
- out_ovf  out  1  this result saturated in re or im.
- ovf_sticky  out  1  OR of all out_ovf since reset or the last clear.
- ovf_clr  in  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, out_valid = 0, p_re = p_im = 0, out_ovf = 0, ovf_sticky = 0. Data registers are reset too. Reset mid-stream discards all in-flight samples.
- Global pipeline enable: adv = !out_valid | out_ready. in_ready = adv, combinational. A sample is accepted when in_valid & in_ready. All stages shift when adv = 1 and hold when adv = 0. Bubbles travel as valid = 0.
- Stage S1 registers a_re, a_im, b_re, b_im, rnd_mode and valid.
- Stage S2 registers four signed 2·WIDTH products: rr = a_re·b_re, ii = a_im·b_im, ri = a_re·b_im, ir = a_im·b_re.
- Stage S3 (output register):
  - Sums are 2·WIDTH+1 bits signed: re = rr - ii, im = ri + ir.
  - If rnd_mode = 1, add 2^(FRAC-1) before the shift.
  - Arithmetic shift right by FRAC.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency: 3 cycles from acceptance to out_valid when unstalled. Throughput is 1 sample per cycle.
- A result is held stable while out_valid & !out_ready. Order is preserved and no sample is lost or duplicated.
- out_ovf = 1 with a result if either component was clamped.
- ovf_sticky is set on any transferred (out_valid & out_ready) result with out_ovf = 1.
  - ovf_clr = 1 clears it.
  - Clear and set in the same cycle: set wins.
- Boundary cases:
  - -1·-1 (0x8000·0x8000, Q1.15) saturates to 0x7FFF with out_ovf = 1.
  - Rounding of -0.5 LSB with rnd_mode = 1 gives 0.
  - Truncation of -0.5 LSB gives -1 LSB (floor).
- in_valid with adv = 0 is not accepted; the source must hold the sample.

Decomposition:
- Shared package fft_fx_pkg:
  - RND_TRUNC = 1'b0, RND_HALFUP = 1'b1.
  - Function or constant for SAT_MAX/SAT_MIN derived from WIDTH.
- One sub-module, fx_round_sat (params IN_W, OUT_W, FRAC). Combinational round + shift + saturate + ovf. Instantiated twice (re, im) in S3.

Test Plan:
- Q1.15. a = 0x4000 + j0x4000, b = 0x4000 + j0xC000 -> after 3 cycles p_re = 0x4000, p_im = 0x0000, out_ovf = 0.
- a = 0x8000 + j0, b = 0x8000 + j0 -> p_re = 0x7FFF, p_im = 0, out_ovf = 1. ovf_sticky = 1 until ovf_clr, then 0.
- a_re = 0x0001, b_re = 0x4000, imag = 0:
  - rnd_mode = 0 -> p_re = 0x0000.
  - rnd_mode = 1 -> 0x0001.
  - With a_re = 0xFFFF: rnd_mode = 0 -> 0xFFFF; rnd_mode = 1 -> 0x0000.
- Stream 20 random samples with in_valid = 1 and out_ready low for cycles 5..9 -> in_ready = 0 during the stall. Output sequence matches the golden model in order, with no drops or duplicates.
- Pull rst_n low for 1 cycle with 3 samples in flight -> out_valid = 0 and outputs 0 immediately. No stale results appear after release. Next input produces a correct result 3 cycles after acceptance.
- Random full-range regression (10k samples, WIDTH = 12, FRAC = 8 variant included) vs a bit-exact reference model -> zero mismatches.
